// File: rtl/fx_pipe_pkg.sv
// fx_pipe_pkg: shared constants, stage type and sizing helper for the fixed-point delay pipe.
package fx_pipe_pkg;
   localparam int FX_DELAY_MAX_DEPTH = 64;
   localparam int FX_DATA_W = 13;
   typedef struct packed {
      logic                 vld;
      logic [FX_DATA_W-1:0] data;
   } fx_stage_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fx_pipe_stage.sv
// fx_pipe_stage: one elastic register stage; advances when empty or when its successor advances.
module fx_pipe_stage
   import fx_pipe_pkg::*;
#(
   parameter int WIDTH = FX_DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             src_vld,
   input  logic [WIDTH-1:0] src_data,
   input  logic             nxt_adv,
   output logic             vld,
   output logic [WIDTH-1:0] data,
   output logic             adv
);
   assign adv = !vld | nxt_adv;
   // bubbles move only the valid bit so the data register stays quiet
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (flush) vld <= 1'b0;
      else if (adv) begin
         vld <= src_vld;
         if (src_vld) data <= src_data;
      end
endmodule

// File: rtl/fx_delay_pipe.sv
// fx_delay_pipe: elastic, bubble-collapsing DEPTH-stage delay line with occupancy count and flush.
module fx_delay_pipe
   import fx_pipe_pkg::*;
#(
   parameter int WIDTH = 13,
   parameter int DEPTH = 1,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [CNT_W-1:0] o_count
);
   if (DEPTH < 0 || DEPTH > FX_DELAY_MAX_DEPTH || CNT_W < clog2(DEPTH + 1)) begin : g_bad_cfg
      $error("fx_delay_pipe: DEPTH out of range or CNT_W too narrow");
   end
   if (DEPTH == 0) begin : g_bypass
      logic unused;
      assign unused  = ^{i_flush, clk, rst};
      assign o_data  = i_data;
      assign o_valid = i_valid;
      assign i_ready = o_ready;
      assign o_count = '0;
   end else begin : g_pipe
      // entry 0 is the input port, entry k+1 is the output of stage k
      logic             v [DEPTH+1];
      logic [WIDTH-1:0] d [DEPTH+1];
      logic             a [DEPTH+1];
      logic [CNT_W-1:0] count;
      logic             in_x, out_x;
      assign v[0]     = i_valid;
      assign d[0]     = i_data;
      assign a[DEPTH] = o_ready;
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         fx_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (i_flush),
            .src_vld  (v[k]),
            .src_data (d[k]),
            .nxt_adv  (a[k+1]),
            .vld      (v[k+1]),
            .data     (d[k+1]),
            .adv      (a[k])
         );
      end
      assign i_ready = a[0] & !i_flush;
      assign o_valid = v[DEPTH];
      assign o_data  = d[DEPTH];
      assign in_x    = i_valid & i_ready;
      assign out_x   = o_valid & o_ready;
      assign o_count = count;
      always_ff @(posedge clk or posedge rst)
         if (rst) count <= '0;
         else if (i_flush) count <= '0;
         else count <= count + CNT_W'(in_x) - CNT_W'(out_x);
   end
endmodule

// File: tb/tb_fx_delay_pipe.sv
// tb_fx_delay_pipe: directed checks of four pipe instances (DEPTH 3, 2, 4, 0) sharing clock and reset.
module tb_fx_delay_pipe;
   localparam logic [3:0][6:0] DEP = {7'd0, 7'd4, 7'd2, 7'd3};
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] i_data [4];
   logic [12:0] o_data [4];
   logic        i_valid [4];
   logic        i_ready [4];
   logic        o_valid [4];
   logic        o_ready [4];
   logic        i_flush [4];
   logic [6:0]  o_count [4];
   int          n_cmp = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : g_dut
      fx_delay_pipe #(.WIDTH(13), .DEPTH(int'(DEP[g])), .CNT_W(7)) u_dut (
         .clk     (clk),
         .rst     (rst),
         .i_flush (i_flush[g]),
         .i_data  (i_data[g]),
         .i_valid (i_valid[g]),
         .i_ready (i_ready[g]),
         .o_data  (o_data[g]),
         .o_valid (o_valid[g]),
         .o_ready (o_ready[g]),
         .o_count (o_count[g])
      );
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [12:0] bp_exp [4];
      int acc, outn, got;
      bp_exp = '{13'h1ABC, 13'h0123, 13'h0456, 13'h0789};
      for (int g = 0; g < 4; g++) begin
         i_data[g] = '0; i_valid[g] = 1'b0; o_ready[g] = 1'b0; i_flush[g] = 1'b0;
      end
      #12 rst = 1'b0;
      // reset mid-stream on DEPTH=3
      tick;
      i_valid[0] = 1'b1; i_data[0] = 13'h0AAA; tick;
      i_data[0] = 13'h0BBB; tick;
      i_valid[0] = 1'b0; tick;
      check("pre_rst_vld", o_valid[0], 1);
      check("pre_rst_data", o_data[0], 13'h0AAA);
      check("pre_rst_cnt", o_count[0], 2);
      #3 rst = 1'b1;
      #1;
      check("rst_vld", o_valid[0], 0);
      check("rst_data", o_data[0], 0);
      check("rst_rdy", i_ready[0], 1);
      check("rst_cnt", o_count[0], 0);
      #2 rst = 1'b0;
      // streaming on DEPTH=3
      o_ready[0] = 1'b1;
      for (int i = 0; i < 14; i++) begin
         i_valid[0] = (i < 10);
         i_data[0]  = 13'(i + 1);
         tick;
         acc  = (i + 1 < 10) ? i + 1 : 10;
         outn = (i < 2) ? 0 : ((i - 2 > 10) ? 10 : i - 2);
         check("st_vld", o_valid[0], (i >= 2 && i < 12));
         if (i >= 2 && i < 12) check("st_data", o_data[0], i - 1);
         check("st_cnt", o_count[0], acc - outn);
      end
      // backpressure on DEPTH=3
      o_ready[0] = 1'b0;
      i_valid[0] = 1'b1; i_data[0] = 13'h1ABC; tick;
      i_data[0] = 13'h0123; tick;
      i_valid[0] = 1'b0; tick;
      check("bp_cnt2", o_count[0], 2);
      check("bp_head_vld", o_valid[0], 1);
      check("bp_head_data", o_data[0], 13'h1ABC);
      i_valid[0] = 1'b1; i_data[0] = 13'h0456; tick;
      check("bp_cnt3", o_count[0], 3);
      i_data[0] = 13'h0789; #1;
      check("bp_full_rdy", i_ready[0], 0);
      tick;
      check("bp_held_cnt", o_count[0], 3);
      o_ready[0] = 1'b1; #1;
      check("bp_sim_rdy", i_ready[0], 1);
      got = 0;
      for (int j = 0; j < 6; j++) begin
         if (j == 1) i_valid[0] = 1'b0;
         #1;
         if (o_valid[0]) begin
            check("bp_data", o_data[0], (got < 4) ? 32'(bp_exp[got]) : 32'hDEAD);
            got++;
         end
         tick;
      end
      check("bp_nout", got, 4);
      check("bp_cnt0", o_count[0], 0);
      // full plus simultaneous on DEPTH=2
      i_valid[1] = 1'b1; i_data[1] = 13'h011; tick;
      i_data[1] = 13'h022; tick;
      check("fs_cnt", o_count[1], 2);
      i_data[1] = 13'h033; #1;
      check("fs_full_rdy", i_ready[1], 0);
      o_ready[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         i_data[1] = 13'(17 * (i + 3));
         #1;
         check("fs_rdy", i_ready[1], 1);
         check("fs_cnt_hold", o_count[1], 2);
         check("fs_vld", o_valid[1], 1);
         check("fs_data", o_data[1], 17 * (i + 1));
         tick;
      end
      i_valid[1] = 1'b0;
      tick; tick;
      check("fs_drain_cnt", o_count[1], 0);
      // flush on DEPTH=4
      i_valid[2] = 1'b1; i_data[2] = 13'h0101; tick;
      i_data[2] = 13'h0202; tick;
      i_data[2] = 13'h0303; tick;
      i_valid[2] = 1'b0; tick;
      check("fl_cnt3", o_count[2], 3);
      check("fl_head", o_data[2], 13'h0101);
      o_ready[2] = 1'b1; i_valid[2] = 1'b1; i_data[2] = 13'h0404; i_flush[2] = 1'b1; #1;
      check("fl_rdy", i_ready[2], 0);
      check("fl_out_vld", o_valid[2], 1);
      tick;
      i_flush[2] = 1'b0; i_valid[2] = 1'b0;
      check("fl_vld0", o_valid[2], 0);
      check("fl_cnt0", o_count[2], 0);
      i_valid[2] = 1'b1; i_data[2] = 13'h0505;
      for (int i = 0; i < 5; i++) begin
         tick;
         i_valid[2] = 1'b0;
         check("fl_lat_vld", o_valid[2], (i == 3));
         if (i == 3) check("fl_lat_data", o_data[2], 13'h0505);
      end
      check("fl_end_cnt", o_count[2], 0);
      // DEPTH=0 passthrough
      i_data[3] = 13'h1FFF;
      for (int i = 0; i < 10; i++) begin
         i_valid[3] = 1'($urandom_range(0, 1));
         o_ready[3] = 1'($urandom_range(0, 1));
         i_flush[3] = 1'($urandom_range(0, 1));
         #1;
         check("pt_data", o_data[3], 13'h1FFF);
         check("pt_vld", o_valid[3], i_valid[3]);
         check("pt_rdy", i_ready[3], o_ready[3]);
         check("pt_cnt", o_count[3], 0);
         tick;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fx_delay_pipe.md
Name: fx_delay_pipe

Overview:
- Elastic, parameterised delay line for fixed-point samples.
- Sits directly downstream of the fixed-point format-match stage and consumes its o_data.
- Gives exactly DEPTH cycles of latency with valid/ready flow control, so a stalled consumer does not corrupt or drop samples.
- Bubble-collapsing: an empty stage is filled even while the output is stalled.

Parameters:
- WIDTH, 13, sample width in bits; data is opaque, no arithmetic is performed.
- DEPTH, 1, number of register stages; legal range 0..64.
- CNT_W, 7, width of the occupancy counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock for all state; rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_flush  input  1  synchronous clear of all stages.
- i_data  input  WIDTH  sample from the format-match stage.
- i_valid  input  1  i_data is valid this cycle.
- i_ready  output  1  pipe accepts i_data this cycle.
- o_data  output  WIDTH  delayed sample.
- o_valid  output  1  o_data is valid.
- o_ready  input  1  downstream consumer accepts o_data.
- o_count  output  CNT_W  number of valid stages currently held (0..DEPTH).

Behaviour:
- State per stage k (0 = input side, DEPTH-1 = output side): data_k[WIDTH], vld_k.
- o_data = data_{DEPTH-1}; o_valid = vld_{DEPTH-1}.
- Reset, asynchronous, rst high: all vld_k = 0, all data_k = 0, o_count = 0.
  - Consequently o_valid = 0, o_data = 0, i_ready = 1.
- Advance rule, evaluated combinationally from the output side toward the input side:
  - adv_{DEPTH-1} = !vld_{DEPTH-1} | o_ready.
  - adv_k = !vld_k | adv_{k+1}.
  - i_ready = adv_0.
- Stage update on a clock edge when adv_k = 1:
  - Stage 0 loads i_data and vld_0 = i_valid.
  - Stage k > 0 loads stage k-1 contents.
  - Stages with adv_k = 0 hold their contents.
- Data registers load only when the incoming vld is 1. Invalid bubbles propagate the valid bit only, which keeps toggling low.
- Transfers:
  - Input transfer = i_valid & i_ready.
  - Output transfer = o_valid & o_ready.
- Latency:
  - With o_ready held high, a sample accepted at edge n appears on o_data with o_valid = 1 after edge n+DEPTH-1; it is registered at n and visible for one cycle.
  - Throughput is 1 sample/cycle.
- o_count is a registered counter:
  - +1 on an input transfer without an output transfer.
  - -1 on an output transfer without an input transfer.
  - Unchanged when both or neither occur.
  - It must equal the popcount of vld_k at all times.
- Full condition: o_count == DEPTH and o_ready = 0, so i_ready = 0.
  - i_data is ignored and the upstream stage must hold.
- Simultaneous: when full and o_ready = 1, input and output transfers occur in the same cycle; i_ready = 1 and o_count is unchanged.
- i_flush, synchronous:
  - Next edge clears all vld_k and sets o_count = 0.
  - Data contents are don't-care.
  - i_ready is forced 0 during the flush cycle, so no input is accepted.
  - Any output transfer in that cycle still completes.
  - Flush has priority over every advance.
- Reset mid-stream: all in-flight samples are discarded immediately (asynchronously). There is no output glitch beyond o_valid dropping.
- DEPTH = 0 is pure combinational passthrough:
  - o_data = i_data, o_valid = i_valid, i_ready = o_ready, o_count = 0.
  - i_flush has no effect.
- Data is never modified, reordered or duplicated. Each accepted sample produces exactly one output transfer unless it is flushed or reset.

Decomposition:
- Shared package fx_pipe_pkg holds:
  - Constant FX_DELAY_MAX_DEPTH = 64.
  - Function clog2 used to check CNT_W at elaboration.
  - Typedef fx_stage_t = packed struct {logic vld; logic [WIDTH-1:0] data}.
- One natural sub-module, fx_pipe_stage: one register stage with its advance logic, instantiated DEPTH times via generate.
- The top level holds the count register, the flush logic and the DEPTH = 0 bypass.

Test Plan:
- Reset/idle: DEPTH=3; assert rst mid-cycle then release -> o_valid=0, o_data=0, i_ready=1, o_count=0 immediately, with no clock edge needed.
- Streaming: DEPTH=3, o_ready=1; send 0x0001..0x000A on consecutive cycles -> each appears exactly 3 edges later, in order, o_count steady at 3.
- Backpressure: DEPTH=3; send 0x1ABC, 0x0123 with o_ready=0 -> o_count climbs to 2, bubble collapses, 0x1ABC held at output. After 2 further inputs, o_count=3 and i_ready=0. Raise o_ready -> all 4 samples drain in order, no loss or duplication.
- Full plus simultaneous: DEPTH=2 full, i_valid=1, o_ready=1 for 5 cycles -> i_ready=1 each cycle, o_count stays 2, 1 sample/cycle out.
- Flush: DEPTH=4 holding 3 samples, o_ready=1, pulse i_flush while i_valid=1 -> output transfer completes that cycle, input not accepted. Next cycle o_valid=0 and o_count=0. The next accepted sample emerges 4 edges later.
- Passthrough: DEPTH=0; toggle i_valid/o_ready randomly with i_data=0x1FFF -> o_data, o_valid and i_ready mirror the inputs in the same cycle, o_count=0.
